binary_sub_13_serial: RTL and testbench
=======================================

# binary_sub_13_serial

Bit-serial 13-bit unsigned subtractor. It computes D = A − B one bit per clock and reports a borrow. It is the inverse-direction companion to the 13-bit registered adder and sits beside it in the arithmetic block set. A start/busy/done handshake replaces the adder's single-cycle path, which keeps the datapath to a one-bit full subtractor, a bit counter and a shift register.

## Interface
- Parameters: none; width is fixed at 13 bits.
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  global enable; when low, every register holds its value.
- start  input  1  request a subtraction; sampled only in IDLE.
- A  input  13  minuend, unsigned; captured on the accepting edge.
- B  input  13  subtrahend, unsigned; captured on the accepting edge.
- D  output  13  difference (A − B) mod 8192, registered; reset 0.
- borrow  output  1  1 when A < B (unsigned), registered; reset 0.
- busy  output  1  1 while in RUN; reset 0.
- done  output  1  1 while in DONE; reset 0.

## Operation
- FSM states are IDLE, RUN and DONE. Reset forces IDLE.
- IDLE:
  - On an edge with en=1 and start=1, capture A into opa and B into opb, clear the internal borrow bw, set cnt=0, and go to RUN.
  - D and borrow keep the previous result.
- RUN: on each edge with en=1, process bit cnt, taking a0=opa[0] and b0=opb[0]:
  - d = a0 ^ b0 ^ bw
  - bw_next = (~a0 & b0) | (~(a0 ^ b0) & bw)
  - Shift opa and opb right by 1.
  - Shift sr right by 1 with d inserted at sr[12].
  - cnt increments.
- RUN terminal step (cnt=12):
  - Load D <= {d, sr[12:1]} and borrow <= bw_next.
  - Go to DONE.
  - sr must not drive D before this point.
- DONE: on the next edge with en=1, go to IDLE. start is ignored in DONE.
- start is ignored in RUN; operands already captured are not disturbed.
- en=0 freezes the state, cnt, the shift registers, bw and all outputs, including done and busy.
- Width rule: D is the 13-bit wrap-around difference. borrow is the 14th bit, i.e. borrow=1 ⇔ A<B. A=B gives D=0 with borrow=0.
- Async reset while in any state immediately clears D, borrow, busy, done, cnt, bw and sr and returns to IDLE. The in-flight operation is discarded; no done is produced for it.

## Timing
- Edge E0 accepts start (en=1). busy=1 from after E0.
- Edges E1..E13 process bits 0..12, one per enabled edge.
- After E13: busy=0, done=1, and D/borrow are valid.
- After E14: done=0 and the FSM is back in IDLE. The earliest next acceptance is E15.
- Latency with en held high: 13 edges from acceptance to done. The cycle period is 15 edges per operation including the IDLE turnaround.
- Each en=0 edge adds one edge of delay in any state.
- done is a single-cycle pulse when en=1.
- D and borrow change only at the terminal RUN edge or on reset, and are stable at all other times.

## Test plan
- Reset, then A=5000, B=3000, start for one edge → D=2000, borrow=0. done high exactly in the cycle after the 13th RUN edge, for one cycle. busy high for 13 cycles.
- A=0, B=1 → D=8191, borrow=1. A=8191, B=8191 → D=0, borrow=0. A=8191, B=0 → D=8191, borrow=0.
- A=100, B=37, with en dropped low for 3 edges mid-RUN → D=63, borrow=0. done asserts 3 edges later than nominal, and outputs/state are frozen during the stall.
- During RUN, pulse start with A=1, B=2 → ignored. The first operation's result is produced unchanged and no second operation starts.
- Assert rst_n=0 asynchronously mid-RUN (between edges) → D, borrow, busy, done all read 0 immediately. After release, the FSM is in IDLE and done does not assert until a new start is given.
- Randomized sweep of 2000 A/B pairs, each checked against (A−B) mod 8192 and (A<B).

Source files
------------

// File: rtl/binary_sub_13_serial.sv
// Bit-serial 13-bit unsigned subtractor: D = A - B, one bit per enabled clock,
// with a start/busy/done handshake and a registered borrow (A < B).
module binary_sub_13_serial (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        start,
  input  logic [12:0] A,
  input  logic [12:0] B,
  output logic [12:0] D,
  output logic        borrow,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [12:0] opa_q, opa_d;
  logic [12:0] opb_q, opb_d;
  logic [12:0] sr_q, sr_d;
  logic        bw_q, bw_d;
  logic [12:0] d_q, d_d;
  logic        borrow_q, borrow_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        dbit;
  logic        bw_nx;

  // One-bit full subtractor on the current LSBs.
  always_comb begin
    dbit  = opa_q[0] ^ opb_q[0] ^ bw_q;
    bw_nx = (~opa_q[0] & opb_q[0]) | (~(opa_q[0] ^ opb_q[0]) & bw_q);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    sr_d     = sr_q;
    bw_d     = bw_q;
    d_d      = d_q;
    borrow_d = borrow_q;

    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            opa_d   = A;
            opb_d   = B;
            bw_d    = 1'b0;
            cnt_d   = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          opa_d = {1'b0, opa_q[12:1]};
          opb_d = {1'b0, opb_q[12:1]};
          sr_d  = {dbit, sr_q[12:1]};
          bw_d  = bw_nx;
          cnt_d = cnt_q + 4'd1;
          // Last bit: publish the result directly from the shifter's next value.
          if (cnt_q == 4'd12) begin
            d_d      = {dbit, sr_q[12:1]};
            borrow_d = bw_nx;
            state_d  = DONE;
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      sr_q     <= '0;
      bw_q     <= 1'b0;
      d_q      <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      sr_q     <= sr_d;
      bw_q     <= bw_d;
      d_q      <= d_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign D      = d_q;
  assign borrow = borrow_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_binary_sub_13_serial.sv
// Self-checking bench for binary_sub_13_serial: scoreboard of expected
// {borrow, D} pushed at start, popped when done is observed.
module tb_binary_sub_13_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        start;
  logic [12:0] A;
  logic [12:0] B;
  logic [12:0] D;
  logic        borrow;
  logic        busy;
  logic        done;

  int checks = 0;
  int fails  = 0;
  logic [13:0] sb[$];

  binary_sub_13_serial dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .start  (start),
    .A      (A),
    .B      (B),
    .D      (D),
    .borrow (borrow),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] model(input logic [12:0] a, input logic [12:0] b);
    logic [12:0] diff;
    diff = a - b;
    return {(a < b), diff};
  endfunction

  // Drive one start, push expectation, wait (bounded) for done.
  task automatic run_op(input logic [12:0] a, input logic [12:0] b,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    sb.push_back(model(a, b));
    @(negedge clk);
    start = 1'b0;
    lat = 0; busy_cnt = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b1; start = 1'b0; A = '0; B = '0;
    #3;
    checks++;
    if ({D, borrow, busy, done} !== 16'h0) begin
      fails++;
      $display("FAIL reset_outputs: got D=%0d borrow=%b busy=%b done=%b, want all 0", D, borrow, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat, bc;
    logic [13:0] exp;
    run_op(13'd5000, 13'd3000, lat, bc);
    exp = sb.pop_front();
    checks++;
    if (lat != 13) begin
      fails++;
      $display("FAIL basic_latency: got %0d edges, want 13", lat);
    end
    checks++;
    if (bc != 13) begin
      fails++;
      $display("FAIL basic_busy_cycles: got %0d, want 13", bc);
    end
    checks++;
    if ({borrow, D} !== exp) begin
      fails++;
      $display("FAIL basic_result: got D=%0d borrow=%b, want D=%0d borrow=%b", D, borrow, exp[12:0], exp[13]);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_done_pulse: got done=%b busy=%b one cycle later, want 0 0", done, busy);
    end
    checks++;
    if (D !== 13'd2000 || borrow !== 1'b0) begin
      fails++;
      $display("FAIL basic_hold: got D=%0d borrow=%b in IDLE, want 2000 0", D, borrow);
    end
  endtask

  task automatic test_corners;
    logic [12:0] ta[3] = '{13'd0, 13'd8191, 13'd8191};
    logic [12:0] tb_[3] = '{13'd1, 13'd8191, 13'd0};
    int lat, bc;
    logic [13:0] exp;
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb_[i], lat, bc);
      exp = sb.pop_front();
      checks++;
      if (lat >= 100 || {borrow, D} !== exp) begin
        fails++;
        $display("FAIL corner_%0d: got D=%0d borrow=%b lat=%0d, want D=%0d borrow=%b", i, D, borrow, lat, exp[12:0], exp[13]);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        fails++;
        $display("FAIL corner_%0d_done_pulse: got done=%b, want 0", i, done);
      end
    end
  endtask

  task automatic test_stall;
    int lat;
    logic [13:0] exp;
    logic [12:0] d_snap;
    logic        ok;
    d_snap = D;
    @(negedge clk);
    A = 13'd100; B = 13'd37; start = 1'b1;
    sb.push_back(model(13'd100, 13'd37));
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    repeat (5) begin
      @(negedge clk);
      lat++;
    end
    en = 1'b0;
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      lat++;
      if (busy !== 1'b1 || done !== 1'b0 || D !== d_snap) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL stall_frozen: got busy=%b done=%b D=%0d, want 1 0 %0d", busy, done, D, d_snap);
    end
    en = 1'b1;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    exp = sb.pop_front();
    checks++;
    if (lat != 16) begin
      fails++;
      $display("FAIL stall_latency: got %0d edges, want 16", lat);
    end
    checks++;
    if ({borrow, D} !== exp) begin
      fails++;
      $display("FAIL stall_result: got D=%0d borrow=%b, want D=%0d borrow=%b", D, borrow, exp[12:0], exp[13]);
    end
    @(negedge clk);
  endtask

  task automatic test_start_ignored;
    int lat;
    logic [13:0] exp;
    logic ok;
    @(negedge clk);
    A = 13'd1000; B = 13'd300; start = 1'b1;
    sb.push_back(model(13'd1000, 13'd300));
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    repeat (4) begin
      @(negedge clk);
      lat++;
    end
    A = 13'd1; B = 13'd2; start = 1'b1;
    @(negedge clk);
    lat++;
    start = 1'b0;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    exp = sb.pop_front();
    checks++;
    if (lat != 13 || {borrow, D} !== exp) begin
      fails++;
      $display("FAIL start_ignored_result: got D=%0d borrow=%b lat=%0d, want D=%0d borrow=%b lat=13", D, borrow, lat, exp[12:0], exp[13]);
    end
    ok = 1'b1;
    repeat (16) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL start_ignored_no_second_op: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_async_reset;
    int lat, bc;
    logic [13:0] exp;
    logic ok;
    @(negedge clk);
    A = 13'd4000; B = 13'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({D, borrow, busy, done} !== 16'h0) begin
      fails++;
      $display("FAIL async_reset_outputs: got D=%0d borrow=%b busy=%b done=%b, want all 0", D, borrow, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL async_reset_idle: got busy=%b done=%b after release, want 0 0", busy, done);
    end
    run_op(13'd10, 13'd3, lat, bc);
    exp = sb.pop_front();
    checks++;
    if (lat != 13 || {borrow, D} !== exp) begin
      fails++;
      $display("FAIL async_reset_recover: got D=%0d borrow=%b lat=%0d, want D=%0d borrow=%b lat=13", D, borrow, lat, exp[12:0], exp[13]);
    end
  endtask

  task automatic test_random;
    int lat, bc;
    logic [12:0] a, b;
    logic [13:0] exp;
    for (int i = 0; i < 2000; i++) begin
      a = 13'($urandom_range(0, 8191));
      b = (i % 50 == 0) ? a : 13'($urandom_range(0, 8191));
      run_op(a, b, lat, bc);
      exp = sb.pop_front();
      checks++;
      if (lat != 13 || {borrow, D} !== exp) begin
        fails++;
        $display("FAIL random_%0d: A=%0d B=%0d got D=%0d borrow=%b lat=%0d, want D=%0d borrow=%b", i, a, b, D, borrow, lat, exp[12:0], exp[13]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_stall();
    test_start_ignored();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
